// File: rtl/backprop_hidden_update_if.sv
// Bus bundle for the hidden-neuron weight updater: control, weight/input buffer
// port and the shared FP ALU handshake. master = updater, slave = environment.
interface backprop_hidden_update_if #(
    parameter int IDX_W = 2
);
    logic             start;
    logic [31:0]      target;
    logic [31:0]      sigmoid_out;
    logic [31:0]      layer2_weight;
    logic [31:0]      hidden_value;
    logic             busy;
    logic             done;
    logic             err;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [31:0]      rd_x;
    logic [31:0]      rd_w;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [31:0]      wr_data;
    logic             alu_valid;
    logic [1:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic             alu_ack;
    logic [31:0]      alu_res;

    modport master (
        input  start, target, sigmoid_out, layer2_weight, hidden_value,
        input  rd_x, rd_w, alu_ack, alu_res,
        output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output alu_valid, alu_op, alu_a, alu_b
    );

    modport slave (
        output start, target, sigmoid_out, layer2_weight, hidden_value,
        output rd_x, rd_w, alu_ack, alu_res,
        input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  alu_valid, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/backprop_hidden_update.sv
// Sequenced FP32 back-prop updater for one hidden neuron: derives the hidden
// delta once through a shared FP ALU, then rewrites all N_IN input weights.
module backprop_hidden_update #(
    parameter int          N_IN  = 4,
    parameter int          IDX_W = $clog2(N_IN),
    parameter logic [31:0] LR    = 32'h3F000000
) (
    input logic                          clk,
    input logic                          reset_n,
    backprop_hidden_update_if.master     bus
);
    localparam logic [31:0] ONE    = 32'h3F800000;
    localparam logic [1:0]  OP_ADD = 2'd0;
    localparam logic [1:0]  OP_SUB = 2'd1;
    localparam logic [1:0]  OP_MUL = 2'd2;
    localparam logic [3:0]  ST_G   = 4'd8;   // last delta step: g = dh*LR
    localparam logic [3:0]  ST_MUL = 4'd9;   // per-index p = g*x
    localparam logic [3:0]  ST_ADD = 4'd10;  // per-index wn = w + p

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RD, S_CAP, S_WR, S_DONE} state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    state_t           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic [31:0]      t_q, t_d, y_q, y_d, w2_q, w2_d, h_q, h_d;
    logic [31:0]      r_q, r_d, om_q, om_d, hm_q, hm_d;
    logic [31:0]      x_q, x_d, w_q, w_d, p_q, p_d, wn_q, wn_d;
    alu_req_t         req;
    logic             in_alu;

    // r_q is the running product; it ends the delta phase holding g
    always_comb begin
        req = '{op: OP_MUL, a: r_q, b: 32'd0};
        unique case (step_q)
            4'd0:    req = '{op: OP_SUB, a: t_q, b: y_q};
            4'd1:    req = '{op: OP_SUB, a: ONE, b: y_q};
            4'd2:    req = '{op: OP_MUL, a: r_q, b: y_q};
            4'd3:    req = '{op: OP_MUL, a: r_q, b: om_q};
            4'd4:    req = '{op: OP_SUB, a: ONE, b: h_q};
            4'd5:    req = '{op: OP_MUL, a: r_q, b: w2_q};
            4'd6:    req = '{op: OP_MUL, a: r_q, b: h_q};
            4'd7:    req = '{op: OP_MUL, a: r_q, b: hm_q};
            4'd8:    req = '{op: OP_MUL, a: r_q, b: LR};
            4'd9:    req = '{op: OP_MUL, a: r_q, b: x_q};
            4'd10:   req = '{op: OP_ADD, a: w_q, b: p_q};
            default: req = '{op: OP_MUL, a: r_q, b: 32'd0};
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        idx_d   = idx_q;
        err_d   = err_q;
        t_d  = t_q;  y_d  = y_q;  w2_d = w2_q; h_d  = h_q;
        r_d  = r_q;  om_d = om_q; hm_d = hm_q;
        x_d  = x_q;  w_d  = w_q;  p_d  = p_q;  wn_d = wn_q;
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                t_d     = bus.target;
                y_d     = bus.sigmoid_out;
                w2_d    = bus.layer2_weight;
                h_d     = bus.hidden_value;
                err_d   = 1'b0;
                idx_d   = '0;
                step_d  = 4'd0;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: if (bus.alu_ack) begin
                unique case (step_q)
                    4'd1:    om_d = bus.alu_res;
                    4'd4:    hm_d = bus.alu_res;
                    ST_MUL:  p_d  = bus.alu_res;
                    ST_ADD:  wn_d = bus.alu_res;
                    default: r_d  = bus.alu_res;
                endcase
                if (bus.alu_res[30:23] == 8'hFF) err_d = 1'b1;
                if (step_q == ST_G) begin
                    state_d = S_RD;
                end else if (step_q == ST_ADD) begin
                    state_d = S_WR;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = S_ISSUE;
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                x_d     = bus.rd_x;
                w_d     = bus.rd_w;
                step_d  = ST_MUL;
                state_d = S_ISSUE;
            end
            S_WR: begin
                if (idx_q == IDX_W'(N_IN - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            t_q  <= '0; y_q  <= '0; w2_q <= '0; h_q  <= '0;
            r_q  <= '0; om_q <= '0; hm_q <= '0;
            x_q  <= '0; w_q  <= '0; p_q  <= '0; wn_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            t_q  <= t_d;  y_q  <= y_d;  w2_q <= w2_d; h_q  <= h_d;
            r_q  <= r_d;  om_q <= om_d; hm_q <= hm_d;
            x_q  <= x_d;  w_q  <= w_d;  p_q  <= p_d;  wn_q <= wn_d;
        end
    end

    // operands are decoded from registered state, so they hold until the ack
    assign in_alu        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.alu_valid = (state_q == S_ISSUE);
    assign bus.alu_op    = in_alu ? req.op : 2'd0;
    assign bus.alu_a     = in_alu ? req.a  : 32'd0;
    assign bus.alu_b     = in_alu ? req.b  : 32'd0;
    assign bus.rd_en     = (state_q == S_RD);
    assign bus.rd_addr   = bus.rd_en ? idx_q : '0;
    assign bus.wr_en     = (state_q == S_WR);
    assign bus.wr_addr   = bus.wr_en ? idx_q : '0;
    assign bus.wr_data   = bus.wr_en ? wn_q : 32'd0;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_backprop_hidden_update.sv
// Bench for backprop_hidden_update: behavioural FP ALU and weight buffer,
// real-arithmetic reference for the weight update, directed + random runs.
module tb_backprop_hidden_update;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] HALF = 32'h3F000000;
    localparam logic [31:0] LR   = 32'h3F000000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    backprop_hidden_update_if #(.IDX_W(IW)) bus();
    backprop_hidden_update #(.N_IN(N), .IDX_W(IW), .LR(LR)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // ---------------- FP32 <-> real helpers (normals only) ----------------
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real  a;
        int   e;
        logic s;
        s = (v < 0.0);
        a = s ? -v : v;
        if (a != a) return 32'h7FC00000;
        if (a == 0.0) return 32'd0;
        if (a >= 2.0 ** 128) return {s, 8'hFF, 23'd0};
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        if (e + 127 >= 255) return {s, 8'hFF, 23'd0};
        if (e + 127 <= 0) return {s, 31'd0};
        return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] fop(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return r2f(f2r(a) + f2r(b));
            2'd1:    return r2f(f2r(a) - f2r(b));
            default: return r2f(f2r(a) * f2r(b));
        endcase
    endfunction

    // Reference: g = LR * dh, dh = do*w2*h*(1-h), do = (t-y)*y*(1-y)
    function automatic logic [31:0] model_g(input logic [31:0] t, input logic [31:0] y,
                                            input logic [31:0] w2, input logic [31:0] h);
        logic [31:0] d_o, d_h;
        d_o = fop(2, fop(2, fop(1, t, y), y), fop(1, ONE, y));
        d_h = fop(2, fop(2, fop(2, d_o, w2), h), fop(1, ONE, h));
        return fop(2, d_h, LR);
    endfunction

    function automatic logic [31:0] rnd_fp();
        return r2f((real'($urandom_range(200, 1)) - 100.0) / 64.0);
    endfunction

    function automatic logic [31:0] rnd_norm();
        return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    // ---------------- environment models ----------------
    logic [31:0] mem_x [N];
    logic [31:0] mem_w [N];
    bit          rand_lat = 1'b0, stray = 1'b0, force_inf = 1'b0;
    int          cur_lat = 1, lat_cnt = 0;
    logic [31:0] pend;

    int cyc = 0, start_cyc = 0, first_valid_cyc = 0, first_rd_cyc = 0, done_cyc = 0;
    int n_valid = 0, n_rd = 0, n_done = 0, stab_err = 0, ovl_err = 0;
    bit outst = 1'b0, busy_at_done = 1'b0, err_at_done = 1'b0;
    logic [1:0]    s_op;
    logic [31:0]   s_a, s_b;
    logic [IW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    function automatic logic [31:0] alu_result();
        if (force_inf && n_valid == 0) return 32'h7F800000;
        return fop(bus.alu_op, bus.alu_a, bus.alu_b);
    endfunction

    always @(posedge clk) begin
        bus.alu_ack <= 1'b0;
        if (lat_cnt > 1) lat_cnt <= lat_cnt - 1;
        else if (lat_cnt == 1) begin
            bus.alu_ack <= 1'b1;
            bus.alu_res <= pend;
            lat_cnt     <= 0;
        end
        if (bus.alu_valid) begin
            if (cur_lat == 1) begin
                bus.alu_ack <= 1'b1;
                bus.alu_res <= alu_result();
            end else begin
                pend    <= alu_result();
                lat_cnt <= cur_lat - 1;
            end
            cur_lat <= rand_lat ? int'($urandom_range(5, 1)) : 1;
        end else if (stray && lat_cnt == 0) begin
            bus.alu_ack <= 1'b1;
            bus.alu_res <= $urandom;
        end
    end

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_x <= mem_x[bus.rd_addr];
            bus.rd_w <= mem_w[bus.rd_addr];
        end
    end

    // cycle-indexed event recorder; cyc read here is the index of the ending cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.start && !bus.busy && !bus.done && reset_n) begin
            start_cyc <= cyc;
            n_valid   <= 0;
            n_rd      <= 0;
            wa_q.delete();
            wd_q.delete();
        end
        if (!reset_n) outst <= 1'b0;
        else if (bus.alu_valid) begin
            if (outst) ovl_err <= ovl_err + 1;
            if (n_valid == 0) first_valid_cyc <= cyc;
            n_valid <= n_valid + 1;
            outst   <= 1'b1;
            s_op <= bus.alu_op; s_a <= bus.alu_a; s_b <= bus.alu_b;
        end else if (outst) begin
            if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {s_op, s_a, s_b}) stab_err <= stab_err + 1;
            if (bus.alu_ack) outst <= 1'b0;
        end
        if (bus.rd_en) begin
            if (n_rd == 0) first_rd_cyc <= cyc;
            n_rd <= n_rd + 1;
        end
        if (bus.wr_en) begin
            wa_q.push_back(bus.wr_addr);
            wd_q.push_back(bus.wr_data);
        end
        if (bus.done) begin
            done_cyc     <= cyc;
            n_done       <= n_done + 1;
            busy_at_done <= bus.busy;
            err_at_done  <= bus.err;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag, input logic [31:0] exp [N]);
        check({tag, "_nwr"}, wd_q.size(), N);
        for (int i = 0; i < N && i < wd_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa_q[i], i);
            check($sformatf("%s_data%0d", tag, i), wd_q[i], exp[i]);
        end
    endtask

    task automatic kick(input logic [31:0] t, input logic [31:0] y, input logic [31:0] w2, input logic [31:0] h);
        @(posedge clk); #1;
        bus.target = t; bus.sigmoid_out = y; bus.layer2_weight = w2; bus.hidden_value = h;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin got = 1'b1; break; end
        end
        check({tag, "_done_seen"}, got, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_std(input string tag, input logic [31:0] t, input logic [31:0] y,
                           input logic [31:0] w2, input logic [31:0] h);
        logic [31:0] g;
        logic [31:0] exp_w [N];
        kick(t, y, w2, h);
        wait_done(tag, 800);
        g = model_g(t, y, w2, h);
        for (int i = 0; i < N; i++) exp_w[i] = fop(0, mem_w[i], fop(2, g, mem_x[i]));
        check_writes(tag, exp_w);
        check({tag, "_issues"}, n_valid, 9 + 2 * N);
    endtask

    initial begin
        logic [31:0] ew [N];
        bit reached;
        int nw, nd;
        bus.start = 1'b0;
        bus.target = '0; bus.sigmoid_out = '0; bus.layer2_weight = '0; bus.hidden_value = '0;
        for (int i = 0; i < N; i++) begin mem_x[i] = ONE; mem_w[i] = HALF; end

        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {bus.busy, bus.done, bus.err, bus.rd_en, bus.wr_en, bus.alu_valid}, 0);
        check("rst_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        check("rst_wr", {bus.wr_addr, bus.wr_data, bus.rd_addr}, 0);
        reset_n = 1'b1;

        // directed: uniform weights, L=1 timing
        kick(ONE, HALF, HALF, HALF);
        wait_done("t1", 200);
        for (int i = 0; i < N; i++) ew[i] = 32'h3F020000;
        check_writes("t1", ew);
        check("t1_first_valid", first_valid_cyc - start_cyc, 1);
        check("t1_first_rd", first_rd_cyc - start_cyc, 19);
        check("t1_done_cyc", done_cyc - start_cyc, 19 + 7 * N);
        check("t1_busy_at_done", busy_at_done, 0);
        check("t1_err", err_at_done, 0);
        check("t1_issues", n_valid, 17);

        // directed: mixed x/w
        mem_x[0] = 32'h40000000; mem_x[1] = 32'h0; mem_x[2] = ONE; mem_x[3] = 32'hBF800000;
        mem_w[0] = 32'h0; mem_w[1] = ONE; mem_w[2] = 32'h0; mem_w[3] = 32'h0;
        kick(ONE, HALF, HALF, HALF);
        wait_done("t2", 200);
        ew[0] = 32'h3C800000; ew[1] = 32'h3F800000; ew[2] = 32'h3C000000; ew[3] = 32'hBC000000;
        check_writes("t2", ew);

        // zero error -> weights unchanged
        for (int i = 0; i < N; i++) begin mem_x[i] = rnd_norm(); mem_w[i] = rnd_norm(); ew[i] = mem_w[i]; end
        kick(32'h3F333333, 32'h3F333333, rnd_fp(), rnd_fp());
        wait_done("t3", 200);
        check_writes("t3", ew);

        // random latency, stray acks in idle, one ignored mid-run start
        rand_lat = 1'b1;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < N; i++) begin mem_x[i] = rnd_fp(); mem_w[i] = rnd_fp(); end
            @(posedge clk); #1 stray = 1'b1;
            repeat (3) @(posedge clk);
            #1 stray = 1'b0;
            if (it == 0) begin
                kick(rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp());
                repeat (10) @(posedge clk);
                #1 bus.start = 1'b1;
                bus.target = rnd_fp();
                @(posedge clk); #1 bus.start = 1'b0;
                wait_done("r0", 800);
                check("r0_busy_ok", n_valid, 17);
                check("r0_nwr", wd_q.size(), N);
                for (int i = 0; i < N && i < wd_q.size(); i++) check("r0_order", wa_q[i], i);
            end else begin
                run_std($sformatf("r%0d", it), rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp());
            end
        end
        check("r_overlap", ovl_err, 0);
        check("r_stable", stab_err, 0);
        rand_lat = 1'b0;

        // reset in the middle of the index loop
        for (int i = 0; i < N; i++) begin mem_x[i] = ONE; mem_w[i] = HALF; end
        kick(ONE, HALF, HALF, HALF);
        reached = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (n_rd >= 2) begin reached = 1'b1; break; end
        end
        check("rs_reached_loop", reached, 1);
        reset_n = 1'b0;
        #1;
        check("rs_ctrl", {bus.busy, bus.done, bus.err, bus.rd_en, bus.wr_en, bus.alu_valid}, 0);
        check("rs_bus", {bus.alu_a, bus.wr_data}, 0);
        nw = wd_q.size();
        nd = n_done;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rs_no_wr", wd_q.size(), nw);
        check("rs_no_done", n_done, nd);
        check("rs_idle", {bus.busy, bus.alu_valid}, 0);
        kick(ONE, HALF, HALF, HALF);
        wait_done("rs2", 200);
        for (int i = 0; i < N; i++) ew[i] = 32'h3F020000;
        check_writes("rs2", ew);
        check("rs2_done_cyc", done_cyc - start_cyc, 19 + 7 * N);

        // infinity from the ALU sets sticky err; next start clears it
        force_inf = 1'b1;
        kick(ONE, HALF, HALF, HALF);
        wait_done("e1", 300);
        force_inf = 1'b0;
        check("e1_err_at_done", err_at_done, 1);
        check("e1_err_sticky", bus.err, 1);
        check("e1_nwr", wd_q.size(), N);
        kick(ONE, HALF, HALF, HALF);
        check("e2_err_cleared", bus.err, 0);
        wait_done("e2", 200);
        check("e2_err_at_done", err_at_done, 0);
        check_writes("e2", ew);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/backprop_hidden_update.md
Name: backprop_hidden_update

Overview:
- Sequenced IEEE-754 single-precision back-propagation weight updater for one hidden neuron.
- Computes the output delta and the hidden delta once, then updates all N_IN input-side weights of that neuron: w_i_new = w_i + LR·δh·x_i.
- Weights and inputs are read from, and written back to, an external indexed buffer.
- All arithmetic goes through one shared FP ALU over a valid/ack handshake. This replaces single-weight combinational update stages.

Parameters:
- N_IN, 4, number of input weights per hidden neuron (≥2).
- IDX_W, $clog2(N_IN), index width.
- LR, 32'h3F000000, learning rate as an FP32 constant (0.5).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- target  in  32  FP32 target value t
- sigmoid_out  in  32  FP32 network output y
- layer2_weight  in  32  FP32 hidden→output weight w2
- hidden_value  in  32  FP32 hidden activation h
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the final write is complete
- err  out  1  sticky per run; set if any ALU result has exponent 8'hFF
- rd_en  out  1  read strobe
- rd_addr  out  IDX_W  read index
- rd_x  in  32  x_i, valid the cycle after rd_en
- rd_w  in  32  w_i, valid the cycle after rd_en
- wr_en  out  1  write strobe
- wr_addr  out  IDX_W  write index
- wr_data  out  32  w_i_new
- alu_valid  out  1  one-cycle operation issue
- alu_op  out  2  0=add, 1=sub (a−b), 2=mul
- alu_a  out  32  operand a
- alu_b  out  32  operand b
- alu_ack  in  1  one-cycle result strobe, ≥1 cycle after alu_valid
- alu_res  in  32  result, valid with alu_ack

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - Reset mid-run aborts immediately with no further writes or ALU issues.
  - An ack that arrives after reset is ignored.
- Start handling:
  - On start in IDLE, latch t, y, w2 and h, clear err, and set the index i=0.
  - start is ignored while busy.
- ALU operation sequence. Each step issues alu_valid for one cycle, waits for alu_ack, then captures alu_res.
  - e = t − y
  - om = 1.0 − y
  - r = e·y
  - δo = r·om
  - hm = 1.0 − h
  - r = δo·w2
  - r = r·h
  - δh = r·hm
  - g = δh·LR
- Per-index loop for i = 0..N_IN−1:
  - RD: rd_en=1, rd_addr=i.
  - CAP: latch rd_x and rd_w.
  - MUL: p = g·x_i.
  - ADD: wn = w_i + p.
  - WR: wr_en=1, wr_addr=i, wr_data=wn.
  - After WR: if i==N_IN−1 go to DONE; otherwise increment i and return to RD.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then return to IDLE.
- ALU handshake:
  - alu_a, alu_b and alu_op are stable from the issue cycle until the ack.
  - At most one operation is outstanding.
  - alu_ack received outside a wait state is ignored.
- Timing with ALU latency L (ack L cycles after valid): each ALU step takes L+1 cycles. For L=1, start accepted at cycle 0:
  - first alu_valid at cycle 1
  - deltas finish at cycle 18
  - each index takes 7 cycles
  - done at cycle 19+7·N_IN
- Writes occur in ascending index order, exactly once per index per run.
- Arithmetic: the block does none itself. The constant 1.0 is 32'h3F800000. No rounding or NaN handling beyond the err exponent check; writes proceed even when err is set.

Test Plan:
- Bench uses a behavioural FP ALU, L=1, N_IN=4.
- t=1.0, y=0.5, w2=0.5, h=0.5, x=1.0, w=0.5 at all indices -> four writes of 32'h3F020000 (0.5078125), done at cycle 47, err=0.
- Same deltas, x={2.0, 0, 1.0, −1.0}, w={0, 32'h3F800000, 0, 0} -> writes {32'h3C800000, 32'h3F800000, 32'h3C000000, 32'hBC000000}, indices 0..3 in order.
- t=y=0.7 -> every wr_data equals the corresponding rd_w.
- ALU latency randomised 1–5 cycles with stray acks injected in IDLE -> identical results, one valid per op, 9+2·4 = 17 issues total.
- Second start pulse mid-run -> ignored. reset_n low during the loop -> all outputs 0 at once and no further wr_en. A fresh start after release completes normally.
- alu_res forced to 32'h7F800000 on the first op -> err=1 through done, cleared by the next start.
